// File: rtl/ram_arb_pkg.sv
// Shared opcodes and FSM encoding for the RAM command arbiter.
package ram_arb_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD2    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RD_CAP  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin picker: prio selects the winner only when both requesters are valid.
module ram_arb_rr2 (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = valid_i;
    if (valid_i == 2'b11) begin
      gnt_o = prio_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter that expands write/read transactions into 10-bit SPI RAM command words.
// Optional address cache (skips repeated address words) enabled by RAM_ARB_ADDR_CACHE_EN.
module ram_cmd_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_SIZE-1:0]  req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_rvalid,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_SIZE-1:0]  req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_rvalid,
  output logic [9:0]            ram_din,
  output logic                  ram_rx_valid,
  input  logic [7:0]            ram_dout,
  input  logic                  ram_tx_valid
);

  state_e                state_q, state_d;
  logic [9:0]            din_q, din_d;
  logic                  rx_q, rx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  id_q, id_d;
  logic                  prio_q, prio_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

  logic [1:0]            gnt;
  logic                  accept;
  logic                  sel_we;
  logic [ADDR_SIZE-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  wr_hit, rd_hit;

  ram_arb_rr2 u_rr2 (
    .valid_i ({req1_valid, req0_valid}),
    .prio_i  (prio_q),
    .gnt_o   (gnt)
  );

  assign accept     = (state_q == ST_IDLE) && (gnt != 2'b00) && !rst;
  assign req0_ready = (state_q == ST_IDLE) && gnt[0] && !rst;
  assign req1_ready = (state_q == ST_IDLE) && gnt[1] && !rst;
  assign sel_we     = gnt[1] ? req1_we    : req0_we;
  assign sel_addr   = gnt[1] ? req1_addr  : req0_addr;
  assign sel_wdata  = gnt[1] ? req1_wdata : req0_wdata;

`ifdef RAM_ARB_ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q;
  logic                 wr_vld_q, rd_vld_q;

  assign wr_hit = wr_vld_q && (wr_addr_q == sel_addr);
  assign rd_hit = rd_vld_q && (rd_addr_q == sel_addr);

  // Track the address most recently sent to the RAM for each direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else if (accept && sel_we && !wr_hit) begin
      wr_vld_q  <= 1'b1;
      wr_addr_q <= sel_addr;
    end else if (accept && !sel_we && !rd_hit) begin
      rd_vld_q  <= 1'b1;
      rd_addr_q <= sel_addr;
    end
  end
`else
  assign wr_hit = 1'b0;
  assign rd_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    rx_d      = rx_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    id_d      = id_q;
    prio_d    = prio_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rx_d = 1'b0;
        if (accept) begin
          prio_d = gnt[0];
          id_d   = gnt[1];
          we_d   = sel_we;
          rx_d   = 1'b1;
          if (sel_we) begin
            wdata_d = sel_wdata;
            if (wr_hit) begin
              din_d = {CMD_WR_DATA, sel_wdata};
            end else begin
              din_d   = {CMD_WR_ADDR, sel_addr};
              state_d = ST_CMD2;
            end
          end else if (rd_hit) begin
            din_d   = {CMD_RD_DATA, 8'h00};
            state_d = ST_RD_WAIT;
          end else begin
            din_d   = {CMD_RD_ADDR, sel_addr};
            state_d = ST_CMD2;
          end
        end
      end
      ST_CMD2: begin
        if (we_q) begin
          din_d   = {CMD_WR_DATA, wdata_q};
          state_d = ST_IDLE;
        end else begin
          din_d   = {CMD_RD_DATA, 8'h00};
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        rx_d    = 1'b0;
        state_d = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        if (ram_tx_valid) begin
          if (id_q) begin
            rdata1_d  = ram_dout;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = ram_dout;
            rvalid0_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      din_q     <= '0;
      rx_q      <= 1'b0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      id_q      <= 1'b0;
      prio_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      rx_q      <= rx_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      id_q      <= id_d;
      prio_q    <= prio_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign ram_din      = din_q;
  assign ram_rx_valid = rx_q;
  assign req0_rdata   = rdata0_q;
  assign req1_rdata   = rdata1_q;
  assign req0_rvalid  = rvalid0_q;
  assign req1_rvalid  = rvalid1_q;

endmodule
